// File: rtl/key_press_gen.sv
// Scripted key-press driver: on request, emits N press/release cycles on key_out,
// optionally with contact-bounce segments around each edge.
module key_press_gen #(
  parameter logic [19:0] HOLD_CYC   = 20'h8_0000,
  parameter logic [19:0] GAP_CYC    = 20'h8_0000,
  parameter logic [7:0]  BOUNCE_CYC = 8'd16,
  parameter logic [2:0]  BOUNCE_NUM = 3'd3,
  parameter logic        KEY_IDLE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_cnt,
  input  logic       bounce_en,
  output logic       key_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_BOUNCE,
    S_HOLD,
    S_R_BOUNCE,
    S_GAP
  } state_t;

  localparam logic [19:0] HOLD_LD  = HOLD_CYC - 20'd1;
  localparam logic [19:0] GAP_LD   = GAP_CYC - 20'd1;
  localparam logic [7:0]  BNC_LD   = BOUNCE_CYC - 8'd1;
  localparam logic [3:0]  SEG_LAST = {BOUNCE_NUM, 1'b0} - 4'd2;

  state_t      state_q, state_d;
  logic [19:0] ph_cnt_q, ph_cnt_d;
  logic [7:0]  b_cnt_q, b_cnt_d;
  logic [3:0]  seg_q, seg_d;
  logic [2:0]  press_q, press_d;
  logic        ben_q, ben_d;
  logic        fin_q, fin_d;
  logic        accept;
  logic        key_act;

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ph_cnt_q <= '0;
      b_cnt_q  <= '0;
      seg_q    <= '0;
      press_q  <= '0;
      ben_q    <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_cnt_q <= ph_cnt_d;
      b_cnt_q  <= b_cnt_d;
      seg_q    <= seg_d;
      press_q  <= press_d;
      ben_q    <= ben_d;
      fin_q    <= fin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    b_cnt_d  = b_cnt_q;
    seg_d    = seg_q;
    press_d  = press_q;
    ben_d    = ben_q;
    fin_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          press_d = req_cnt;
          ben_d   = bounce_en;
          if (req_cnt == 3'd0) begin
            fin_d = 1'b1;
          end else if (bounce_en) begin
            state_d = S_P_BOUNCE;
            seg_d   = '0;
            b_cnt_d = BNC_LD;
          end else begin
            state_d  = S_HOLD;
            ph_cnt_d = HOLD_LD;
          end
        end
      end
      S_P_BOUNCE: begin
        if (b_cnt_q != 8'd0) begin
          b_cnt_d = b_cnt_q - 8'd1;
        end else if (seg_q == SEG_LAST) begin
          state_d  = S_HOLD;
          ph_cnt_d = HOLD_LD;
        end else begin
          seg_d   = seg_q + 4'd1;
          b_cnt_d = BNC_LD;
        end
      end
      S_HOLD: begin
        if (ph_cnt_q != 20'd0) begin
          ph_cnt_d = ph_cnt_q - 20'd1;
        end else if (ben_q) begin
          state_d = S_R_BOUNCE;
          seg_d   = '0;
          b_cnt_d = BNC_LD;
        end else begin
          state_d  = S_GAP;
          ph_cnt_d = GAP_LD;
        end
      end
      S_R_BOUNCE: begin
        if (b_cnt_q != 8'd0) begin
          b_cnt_d = b_cnt_q - 8'd1;
        end else if (seg_q == SEG_LAST) begin
          state_d  = S_GAP;
          ph_cnt_d = GAP_LD;
        end else begin
          seg_d   = seg_q + 4'd1;
          b_cnt_d = BNC_LD;
        end
      end
      S_GAP: begin
        if (ph_cnt_q != 20'd0) begin
          ph_cnt_d = ph_cnt_q - 20'd1;
        end else begin
          press_d = press_q - 3'd1;
          if (press_q == 3'd1) begin
            state_d = S_IDLE;
            fin_d   = 1'b1;
          end else if (ben_q) begin
            state_d = S_P_BOUNCE;
            seg_d   = '0;
            b_cnt_d = BNC_LD;
          end else begin
            state_d  = S_HOLD;
            ph_cnt_d = HOLD_LD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Press bounce starts active (even segments); release bounce starts idle.
  always_comb begin
    key_act = 1'b0;
    case (state_q)
      S_P_BOUNCE: key_act = ~seg_q[0];
      S_HOLD:     key_act = 1'b1;
      S_R_BOUNCE: key_act = seg_q[0];
      default:    key_act = 1'b0;
    endcase
  end

  // Outputs lag the FSM by one cycle so the first key edge lands one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out   <= KEY_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      key_out <= KEY_IDLE ^ key_act;
      busy    <= (state_q != S_IDLE);
      done    <= fin_q;
      if (accept)
        req_ready <= 1'b0;
      else if (state_q == S_IDLE)
        req_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_press_gen.sv
// Randomized self-checking bench for key_press_gen against a per-cycle waveform model.
module tb_key_press_gen;

  localparam int HOLD = 8;
  localparam int GAP  = 6;
  localparam int BC   = 2;
  localparam int BN   = 2;
  localparam logic IDLE_LVL = 1'b1;
  localparam int SB = (2 * BN - 1) * BC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_cnt = '0;
  logic       bounce_en = 1'b0;
  logic       key_out;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  key_press_gen #(
    .HOLD_CYC  (20'(HOLD)),
    .GAP_CYC   (20'(GAP)),
    .BOUNCE_CYC(8'(BC)),
    .BOUNCE_NUM(3'(BN)),
    .KEY_IDLE  (IDLE_LVL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cnt  (req_cnt),
    .bounce_en(bounce_en),
    .key_out  (key_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic int press_len(input logic ben);
    return HOLD + GAP + (ben ? 2 * SB : 0);
  endfunction

  // Expected key level in cycle k (1-based) after acceptance.
  function automatic logic key_at(input int k, input logic ben);
    int off;
    logic act;
    off = (k - 1) % press_len(ben);
    act = 1'b0;
    if (ben && off < SB) begin
      act = ((off / BC) % 2) == 0;
    end else begin
      if (ben) off = off - SB;
      if (off < HOLD) act = 1'b1;
      else begin
        off = off - HOLD;
        if (ben && off < SB) act = ((off / BC) % 2) == 1;
      end
    end
    return act ? ~IDLE_LVL : IDLE_LVL;
  endfunction

  task automatic run_req(input int cnt, input logic ben, input logic noise);
    int guard;
    int total;
    logic exp_key;
    logic exp_busy;
    logic exp_done;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_wait: req_ready=%b required 1 (cnt=%0d)", req_ready, cnt);
    end
    req_valid = 1'b1;
    req_cnt   = 3'(cnt);
    bounce_en = ben;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_cnt   = 3'($urandom);
    bounce_en = 1'($urandom);
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_drop: req_ready=%b required 0", req_ready);
    end
    total = cnt * press_len(ben);
    for (int k = 1; k <= total + 1; k++) begin
      if (noise && k <= total) begin
        req_valid = 1'($urandom);
        req_cnt   = 3'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      exp_key  = (k <= total) ? key_at(k, ben) : IDLE_LVL;
      exp_busy = (k <= total);
      exp_done = (k == total + 1);
      tests++;
      if (key_out !== exp_key || busy !== exp_busy || done !== exp_done ||
          req_ready !== exp_done) begin
        fails++;
        $display("FAIL seq cnt=%0d ben=%b cyc=T+%0d: key/busy/done/ready=%b%b%b%b required %b%b%b%b",
                 cnt, ben, k, key_out, busy, done, req_ready,
                 exp_key, exp_busy, exp_done, exp_done);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (key_out !== IDLE_LVL || req_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: key/ready/busy/done=%b%b%b%b required 1000",
               key_out, req_ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: req_ready=%b required 0", req_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_directed();
    run_req(1, 1'b0, 1'b0);
    run_req(3, 1'b0, 1'b0);
    run_req(1, 1'b1, 1'b0);
    run_req(0, 1'b0, 1'b0);
    run_req(2, 1'b0, 1'b1);
    run_req(7, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_req(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    // The bench's run_req issues the next request in the done cycle.
    for (int i = 0; i < 3; i++)
      run_req(1 + i, 1'(i % 2), 1'b0);
  endtask

  task automatic test_mid_reset();
    req_valid = 1'b1;
    req_cnt   = 3'd1;
    bounce_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (key_out !== ~IDLE_LVL) begin
      fails++;
      $display("FAIL hold_level: key_out=%b required %b", key_out, ~IDLE_LVL);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (key_out !== IDLE_LVL || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: key/busy/done=%b%b%b required 100", key_out, busy, done);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_abort: req_ready=%b required 1", req_ready);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || key_out !== IDLE_LVL || busy !== 1'b0) begin
        fails++;
        $display("FAIL post_abort cyc=%0d: key/busy/done=%b%b%b required 100",
                 k, key_out, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    run_req(1, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
